diag_severity_ctrl: RTL and testbench
=====================================

// Module: diag_severity_ctrl
// PURPOSE
//  Consumer side of the diagnostic-directive stream: applies push/pop/set-severity
//  commands to a per-ID severity table with a save/restore stack. Classifies incoming
//  diagnostic events by current severity, counts them, and latches a fatal condition.
//  Sits between the directive decoder and the diagnostic reporter.
// PARAMETERS
//  NUM_IDS      16  number of diagnostic IDs in the severity table
//  STACK_DEPTH   4  number of saved tables (push/pop levels)
//  CNT_W        16  width of saturating warn/error counters
// PORTS
//  clk           in   1                 clock, all logic on rising edge
//  rst_n         in   1                 asynchronous reset, active low
//  cmd_valid     in   1                 directive command valid
//  cmd_ready     out  1                 command accepted when valid&ready
//  cmd_op        in   2                 diag_op_e: NOP/PUSH/POP/SET
//  cmd_id        in   $clog2(NUM_IDS)   target ID (SET only)
//  cmd_sev       in   2                 diag_sev_e: IGNORE/WARN/ERROR/FATAL (SET only)
//  evt_valid     in   1                 diagnostic event strobe
//  evt_id        in   $clog2(NUM_IDS)   event ID
//  out_valid     out  1                 classified event valid (1-cycle pulse)
//  out_id        out  $clog2(NUM_IDS)   echoed event ID
//  out_sev       out  2                 severity applied to event
//  warn_cnt      out  CNT_W             saturating count of WARN events
//  err_cnt       out  CNT_W             saturating count of ERROR events
//  fatal_seen    out  1                 sticky: a FATAL event was classified
//  stack_err     out  1                 sticky: push on full or pop on empty
//  depth         out  $clog2(STACK_DEPTH+1)  current stack occupancy
//  clear         in   1                 sync clear of counters and sticky flags
// BEHAVIOUR
//  - Reset: table all WARN, stack empty, depth=0, out_valid=0, out_id=0, out_sev=WARN,
//    counters 0, fatal_seen=0, stack_err=0, cmd_ready=1. Reset mid-command discards it.
//  - cmd_ready = !fatal_seen; after FATAL, commands stall until clear or reset.
//  - Command takes effect at the accepting edge; visible to events from next cycle.
//  - PUSH: copy whole table to stack[depth], depth++. Table unchanged.
//  - POP: table <= stack[depth-1], depth--.
//  - SET: table[cmd_id] <= cmd_sev. NOP: no effect.
//  - PUSH at depth==STACK_DEPTH or POP at depth==0: no state change, stack_err<=1.
//  - cmd_id >= NUM_IDS on SET: ignored, no flag.
//  - Event: 1-cycle latency; out_valid/out_id/out_sev registered from evt_* and table
//    as it was BEFORE any same-cycle command (event wins old value).
//  - evt_id >= NUM_IDS classified as WARN.
//  - Counters: WARN -> warn_cnt++, ERROR -> err_cnt++, saturate at 2^CNT_W-1, no wrap.
//    IGNORE: out_valid still pulses, nothing counted. FATAL: fatal_seen<=1.
//  - Counters/flags update same edge as out_valid.
//  - clear: counters, fatal_seen, stack_err <= 0; table/stack/depth untouched.
//    clear and a same-cycle counted event: clear wins (result 0).
// STRUCTURE
//  - diag_pkg: diag_sev_e (IGNORE=0,WARN=1,ERROR=2,FATAL=3), diag_op_e
//    (NOP=0,PUSH=1,POP=2,SET=3), DIAG_SEV_DEFAULT=WARN, table type sev_tbl_t.
//  - Sub-module diag_table_stack: LIFO of sev_tbl_t words, push/pop/full/empty/depth.
//  - Top: table register, command decode, event classifier and counters.
// TESTING
//  - Reset, event id=3 -> next cycle out_valid=1, out_sev=WARN, warn_cnt=1.
//  - SET id=5 IGNORE, event id=5 -> out_sev=IGNORE, counters unchanged.
//  - PUSH, SET id=2 ERROR, event id=2 (err_cnt=1), POP, event id=2 -> out_sev=WARN.
//  - 5 PUSHes with STACK_DEPTH=4 -> depth=4, stack_err=1; POP on empty likewise flags.
//  - SET id=7 FATAL and event id=7 same cycle -> out_sev=WARN; next event -> FATAL,
//    fatal_seen=1, cmd_ready=0; clear -> fatal_seen=0, cmd_ready=1.
//  - CNT_W=4, 20 WARN events -> warn_cnt=15 held; assert rst_n low mid-run -> all reset.

Source files
------------

// File: rtl/diag_pkg.sv
// Shared types for the diagnostic severity controller: severity/op encodings
// and the severity table word layout (two bits per diagnostic ID).
package diag_pkg;

    typedef enum logic [1:0] {
        SEV_IGNORE = 2'd0,
        SEV_WARN   = 2'd1,
        SEV_ERROR  = 2'd2,
        SEV_FATAL  = 2'd3
    } diag_sev_e;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_SET  = 2'd3
    } diag_op_e;

    localparam diag_sev_e DIAG_SEV_DEFAULT = SEV_WARN;
    localparam int        DIAG_NUM_IDS     = 16;

    // Entry i occupies bits [2*i+1 : 2*i].
    typedef logic [2*DIAG_NUM_IDS-1:0] sev_tbl_t;

endpackage

// File: rtl/diag_table_stack.sv
// LIFO of whole severity-table words used to save/restore the active table.
// Callers must not push when full or pop when empty; such requests are dropped.
module diag_table_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [DW-1:0]    depth
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DW-1:0]    depth_r;
    logic [DW-1:0]    top_s;

    assign full  = (depth_r == DW'(DEPTH));
    assign empty = (depth_r == {DW{1'b0}});
    assign depth = depth_r;

    // Top-of-stack read port, zero when nothing is saved.
    always_comb begin
        top_s = depth_r - {{(DW-1){1'b0}}, 1'b1};
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[top_s[AW-1:0]];
        end
    end

    // Storage writes on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[depth_r[AW-1:0]] <= wdata;
        end
    end

    // Occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_r <= {DW{1'b0}};
        end else if (push && !full) begin
            depth_r <= depth_r + {{(DW-1){1'b1}} & {(DW-1){1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            depth_r <= depth_r - {{(DW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/diag_severity_ctrl.sv
// Applies push/pop/set directives to a per-ID severity table and classifies
// diagnostic events against it, with saturating counters and sticky flags.
module diag_severity_ctrl
    import diag_pkg::*;
#(
    parameter int NUM_IDS     = 16,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16,
    localparam int ID_W       = $clog2(NUM_IDS),
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ID_W-1:0]    cmd_id,
    input  logic [1:0]         cmd_sev,
    input  logic               evt_valid,
    input  logic [ID_W-1:0]    evt_id,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    output logic [1:0]         out_sev,
    output logic [CNT_W-1:0]   warn_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               fatal_seen,
    output logic               stack_err,
    output logic [DEPTH_W-1:0] depth,
    input  logic               clear
);

    localparam logic [2*NUM_IDS-1:0] TBL_RESET = {NUM_IDS{2'(DIAG_SEV_DEFAULT)}};
    localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

    logic [2*NUM_IDS-1:0] tbl_r;
    logic [2*NUM_IDS-1:0] stk_rdata_s;
    logic                 stk_full_s, stk_empty_s;
    logic                 stk_push_s, stk_pop_s, stk_err_s, set_ok_s;
    logic                 cmd_fire_s;
    logic                 evt_in_range_s, cmd_in_range_s;
    diag_sev_e            evt_sev_s;

    logic                 out_valid_r;
    logic [ID_W-1:0]      out_id_r;
    logic [1:0]           out_sev_r;
    logic [CNT_W-1:0]     warn_cnt_r, err_cnt_r;
    logic                 fatal_seen_r, stack_err_r, cmd_ready_r;

    // A power-of-two table has no unreachable IDs, so the range check folds away.
    if (NUM_IDS == (1 << ID_W)) begin : g_full_range
        assign evt_in_range_s = 1'b1;
        assign cmd_in_range_s = 1'b1;
    end else begin : g_part_range
        assign evt_in_range_s = (32'(evt_id) < NUM_IDS);
        assign cmd_in_range_s = (32'(cmd_id) < NUM_IDS);
    end

    diag_table_stack #(
        .WIDTH (2*NUM_IDS),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push_s),
        .pop   (stk_pop_s),
        .wdata (tbl_r),
        .rdata (stk_rdata_s),
        .full  (stk_full_s),
        .empty (stk_empty_s),
        .depth (depth)
    );

    // Command decode; stack misuse raises an error instead of moving the stack.
    always_comb begin
        cmd_fire_s = cmd_valid && cmd_ready_r;
        stk_push_s = 1'b0;
        stk_pop_s  = 1'b0;
        stk_err_s  = 1'b0;
        set_ok_s   = 1'b0;
        if (cmd_fire_s) begin
            case (diag_op_e'(cmd_op))
                OP_PUSH: begin
                    stk_push_s = !stk_full_s;
                    stk_err_s  = stk_full_s;
                end
                OP_POP: begin
                    stk_pop_s = !stk_empty_s;
                    stk_err_s = stk_empty_s;
                end
                OP_SET:  set_ok_s = cmd_in_range_s;
                default: set_ok_s = 1'b0;
            endcase
        end else begin
            set_ok_s = 1'b0;
        end
    end

    // Event lookup uses the table before any same-cycle command lands.
    always_comb begin
        evt_sev_s = DIAG_SEV_DEFAULT;
        if (evt_in_range_s) begin
            evt_sev_s = diag_sev_e'(tbl_r[{evt_id, 1'b0} +: 2]);
        end else begin
            evt_sev_s = DIAG_SEV_DEFAULT;
        end
    end

    // Active severity table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_r <= TBL_RESET;
        end else if (stk_pop_s) begin
            tbl_r <= stk_rdata_s;
        end else if (set_ok_s) begin
            tbl_r[{cmd_id, 1'b0} +: 2] <= cmd_sev;
        end
    end

    // Classified event output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_id_r    <= {ID_W{1'b0}};
            out_sev_r   <= 2'(DIAG_SEV_DEFAULT);
        end else begin
            out_valid_r <= evt_valid;
            if (evt_valid) begin
                out_id_r  <= evt_id;
                out_sev_r <= 2'(evt_sev_s);
            end
        end
    end

    // Counters and sticky flags; clear overrides anything arriving the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_cnt_r   <= {CNT_W{1'b0}};
            err_cnt_r    <= {CNT_W{1'b0}};
            fatal_seen_r <= 1'b0;
            stack_err_r  <= 1'b0;
            cmd_ready_r  <= 1'b1;
        end else if (clear) begin
            warn_cnt_r   <= {CNT_W{1'b0}};
            err_cnt_r    <= {CNT_W{1'b0}};
            fatal_seen_r <= 1'b0;
            stack_err_r  <= 1'b0;
            cmd_ready_r  <= 1'b1;
        end else begin
            if (evt_valid) begin
                case (evt_sev_s)
                    SEV_WARN: begin
                        if (warn_cnt_r != CNT_MAX) warn_cnt_r <= warn_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    SEV_ERROR: begin
                        if (err_cnt_r != CNT_MAX) err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    SEV_FATAL: begin
                        fatal_seen_r <= 1'b1;
                        cmd_ready_r  <= 1'b0;
                    end
                    default: begin
                        fatal_seen_r <= fatal_seen_r;
                    end
                endcase
            end
            if (stk_err_s) begin
                stack_err_r <= 1'b1;
            end
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign out_valid  = out_valid_r;
    assign out_id     = out_id_r;
    assign out_sev    = out_sev_r;
    assign warn_cnt   = warn_cnt_r;
    assign err_cnt    = err_cnt_r;
    assign fatal_seen = fatal_seen_r;
    assign stack_err  = stack_err_r;

endmodule

// File: tb/tb_diag_severity_ctrl.sv
// Scoreboard bench for diag_severity_ctrl: a reference table/stack model queues
// expected classifications at each edge and a negedge monitor retires them.
module tb_diag_severity_ctrl;

    localparam int NUM_IDS     = 16;
    localparam int STACK_DEPTH = 4;
    localparam int CNT_W       = 4;
    localparam int CMAX        = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_id = 4'd0;
    logic [1:0] cmd_sev = 2'd0;
    logic       evt_valid = 1'b0;
    logic [3:0] evt_id = 4'd0;
    logic       out_valid;
    logic [3:0] out_id;
    logic [1:0] out_sev;
    logic [3:0] warn_cnt, err_cnt;
    logic       fatal_seen, stack_err;
    logic [2:0] depth;
    logic       clear = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] mtbl [NUM_IDS];
    logic [1:0] mstack [STACK_DEPTH][NUM_IDS];
    int         mdepth, mwarn, merr;
    logic       mfatal, mserr;
    logic [5:0] exp_q [$];
    logic [5:0] mon_e;

    diag_severity_ctrl #(
        .NUM_IDS     (NUM_IDS),
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_id     (cmd_id),
        .cmd_sev    (cmd_sev),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_sev    (out_sev),
        .warn_cnt   (warn_cnt),
        .err_cnt    (err_cnt),
        .fatal_seen (fatal_seen),
        .stack_err  (stack_err),
        .depth      (depth),
        .clear      (clear)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_IDS; i++) mtbl[i] = 2'd1;
        mdepth = 0; mwarn = 0; merr = 0;
        mfatal = 1'b0; mserr = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".warn"},  32'(warn_cnt),   32'(mwarn));
        check_eq({tag, ".err"},   32'(err_cnt),    32'(merr));
        check_eq({tag, ".fatal"}, 32'(fatal_seen), 32'(mfatal));
        check_eq({tag, ".serr"},  32'(stack_err),  32'(mserr));
        check_eq({tag, ".depth"}, 32'(depth),      32'(mdepth));
        check_eq({tag, ".ready"}, 32'(cmd_ready),  32'(!mfatal));
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [3:0] id, input logic [1:0] sev);
        cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_sev = sev;
    endtask

    task automatic drive_evt(input logic [3:0] id);
        evt_valid = 1'b1; evt_id = id;
    endtask

    // One clock: the model applies the same edge semantics, then inputs drop.
    task automatic step();
        logic [1:0] s;
        logic       acc, serr_ev;
        @(posedge clk);
        s = 2'd1;
        acc = cmd_valid && !mfatal;
        serr_ev = 1'b0;
        if (evt_valid) begin
            s = mtbl[evt_id];
            exp_q.push_back({evt_id, s});
        end
        if (acc) begin
            case (cmd_op)
                2'd1: if (mdepth == STACK_DEPTH) serr_ev = 1'b1;
                      else begin mstack[mdepth] = mtbl; mdepth++; end
                2'd2: if (mdepth == 0) serr_ev = 1'b1;
                      else begin mdepth--; mtbl = mstack[mdepth]; end
                2'd3: mtbl[cmd_id] = cmd_sev;
                default: ;
            endcase
        end
        if (clear) begin
            mwarn = 0; merr = 0; mfatal = 1'b0; mserr = 1'b0;
        end else begin
            if (evt_valid) begin
                case (s)
                    2'd1: if (mwarn != CMAX) mwarn++;
                    2'd2: if (merr != CMAX) merr++;
                    2'd3: mfatal = 1'b1;
                    default: ;
                endcase
            end
            if (serr_ev) mserr = 1'b1;
        end
        #1;
        cmd_valid = 1'b0; evt_valid = 1'b0; clear = 1'b0;
    endtask

    // Retire expected classifications as the DUT reports them.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("out_id",  32'(out_id),  32'(mon_e[5:2]));
                check_eq("out_sev", 32'(out_sev), 32'(mon_e[1:0]));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.out_id",    32'(out_id),    32'd0);
        check_eq("rst.out_sev",   32'(out_sev),   32'd1);
        check_state("rst");
        rst_n = 1'b1;

        // Default WARN classification
        drive_evt(4'd3); step();
        check_state("warn1");
        check_eq("warn1.cnt", 32'(warn_cnt), 32'd1);

        // IGNORE still pulses out_valid but is not counted
        drive_cmd(2'd3, 4'd5, 2'd0); step();
        drive_evt(4'd5); step();
        check_state("ignore");

        // Push / override / pop restores the saved severity
        drive_cmd(2'd1, 4'd0, 2'd0); step();
        drive_cmd(2'd3, 4'd2, 2'd2); step();
        drive_evt(4'd2); step();
        check_eq("err1.cnt", 32'(err_cnt), 32'd1);
        drive_cmd(2'd2, 4'd0, 2'd0); step();
        drive_evt(4'd2); step();
        check_state("poprestore");

        // Overflow and underflow both flag stack_err
        for (int i = 0; i < 5; i++) begin drive_cmd(2'd1, 4'd0, 2'd0); step(); end
        check_eq("ovf.depth", 32'(depth), 32'd4);
        check_state("ovf");
        clear = 1'b1; step();
        check_state("clr1");
        for (int i = 0; i < 5; i++) begin drive_cmd(2'd2, 4'd0, 2'd0); step(); end
        check_eq("udf.serr", 32'(stack_err), 32'd1);
        check_state("udf");
        clear = 1'b1; step();

        // Event sees the table before a same-cycle SET; FATAL then stalls commands
        drive_cmd(2'd3, 4'd7, 2'd3); drive_evt(4'd7); step();
        drive_evt(4'd7); step();
        check_eq("fatal.ready", 32'(cmd_ready), 32'd0);
        check_state("fatal");
        drive_cmd(2'd3, 4'd3, 2'd2); step();
        drive_evt(4'd3); step();
        check_state("stalled");
        clear = 1'b1; drive_evt(4'd3); step();
        check_eq("clr.warn", 32'(warn_cnt), 32'd0);
        check_eq("clr.ready", 32'(cmd_ready), 32'd1);
        check_state("clr2");

        // Saturation
        for (int i = 0; i < 20; i++) begin drive_evt(4'd3); step(); end
        check_eq("sat.warn", 32'(warn_cnt), 32'd15);
        check_state("sat");

        // Mixed random traffic
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 1) drive_evt(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) != 0)
                drive_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) == 0) clear = 1'b1;
            step();
            check_state("rand");
        end

        // Asynchronous reset in the middle of traffic
        drive_cmd(2'd1, 4'd0, 2'd0); drive_evt(4'd1); step();
        drive_cmd(2'd3, 4'd1, 2'd2); drive_evt(4'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst.out_valid", 32'(out_valid), 32'd0);
        check_eq("arst.out_sev",   32'(out_sev),   32'd1);
        check_state("arst");
        cmd_valid = 1'b0; evt_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive_evt(4'd1); step();
        check_state("postrst");

        @(negedge clk);
        #1;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
